// File: rtl/div_pkg.sv
// div_pkg: shared divider FSM state encoding and constants
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: (W+1)-bit a_i - b_i as chained 4-bit CLA slices (~b, cin=1); ports a_i, b_i in, diff_o difference, neg_o borrow/sign
module div_trial_sub #(
  parameter int W = 32
) (
  input  logic [W:0]   a_i,
  input  logic [W:0]   b_i,
  output logic [W-1:0] diff_o,
  output logic         neg_o
);
  logic [W:0] p;
  logic [W-1:0] g;
  logic cs [0:W/4];
  logic [W-1:0] cb;
  assign p = a_i ^ ~b_i;
  assign g = a_i[W-1:0] & ~b_i[W-1:0];
  assign cs[0] = 1'b1;
  for (genvar k = 0; k < W / 4; k++) begin : g_cla
    localparam int B = 4 * k;
    logic ci;
    assign ci = cs[k];
    assign cb[B] = ci;
    assign cb[B+1] = g[B] | (p[B] & ci);
    assign cb[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
    assign cb[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B]) | (p[B+2] & p[B+1] & p[B] & ci);
    assign cs[k+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1]) | (p[B+3] & p[B+2] & p[B+1] & g[B]) | (p[B+3] & p[B+2] & p[B+1] & p[B] & ci);
  end
  assign diff_o = p[W-1:0] ^ cb;
  assign neg_o = p[W] ^ cs[W/4];
endmodule

// File: rtl/divider_32.sv
// divider_32: multi-cycle restoring signed/unsigned divider; in start/sign/dividend/divisor, out busy/done/quotient/remainder/div_by_zero
module divider_32
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_e state_q, state_d;
  logic [5:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic neg_q_q, neg_r_q, dz_q, div_by_zero_q;
  logic busy_q, done_q, busy_d, done_d;
  logic accept, borrow;
  logic [WIDTH-1:0] rem_sh, trial;
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction
  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign rem_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  div_trial_sub #(.W(WIDTH)) u_sub (
    .a_i   ({1'b0, rem_sh}),
    .b_i   ({1'b0, dvs_q}),
    .diff_o(trial),
    .neg_o (borrow)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE, DONE: state_d = accept ? (divisor == '0 ? FIX : RUN) : IDLE;
      RUN:        state_d = (cnt_q == 6'(DIV_ITER - 1)) ? FIX : RUN;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_d = state_d == RUN || state_d == FIX;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= mag(dividend, sign);
      dvs_q   <= mag(divisor, sign);
      dvd_q   <= dividend;
      neg_q_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_q <= sign & dividend[WIDTH-1];
      dz_q    <= divisor == '0;
    end else if (state_q == RUN) begin
      rem_q <= borrow ? rem_sh : trial;
      quo_q <= {quo_q[WIDTH-2:0], ~borrow};
      cnt_q <= cnt_q + 6'd1;
    end else if (state_q == FIX) begin
      quotient_q    <= dz_q ? DIV_ZERO_Q : (neg_q_q ? -quo_q : quo_q);
      remainder_q   <= dz_q ? dvd_q : (neg_r_q ? -rem_q : rem_q);
      div_by_zero_q <= dz_q;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
  assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_divider_32.sv
// tb_divider_32: directed and random scoreboard bench for divider_32
module tb_divider_32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int checks = 0, failures = 0;
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb[$];
  divider_32 dut (
    .clk(clk), .rst(rst), .start(start), .sign(sign),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz, input int lat);
    @(negedge clk);
    start = 1'b1;
    sign = s;
    dividend = a;
    divisor = b;
    if (push) sb.push_back('{q: eq, r: er, dz: edz, lat: 8'(lat)});
    @(posedge clk);
    #1;
    start = 1'b0;
    sign = 1'($urandom);
    dividend = $urandom;
    divisor = $urandom;
  endtask
  task automatic complete(input string tag, input int inject_at);
    int c = 1, nb = 0;
    logic both = 1'b0;
    exp_t e;
    while (!done && c < 60) begin
      both |= busy & done;
      if (busy) nb++;
      start = (c == inject_at);
      @(posedge clk);
      #1;
      c++;
    end
    start = 1'b0;
    both |= busy & done;
    check({tag, "_pending"}, 32'(sb.size()), 32'd1);
    e = sb.size() > 0 ? sb.pop_front() : '0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(c), 32'(e.lat));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(e.lat) - 32'd1);
    check({tag, "_busy_and_done"}, 32'(both), 32'd0);
    check({tag, "_quotient"}, quotient, e.q);
    check({tag, "_remainder"}, remainder, e.r);
    check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
  endtask
  initial begin
    logic seen;
    logic s;
    logic [31:0] a, b, eq, er;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34);
    complete("u_100_7", 0);
    issue(1'b1, -32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    complete("s_m100_7", 0);
    issue(1'b1, 32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    complete("s_100_m7", 0);
    issue(1'b0, 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2);
    complete("div_zero", 0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
    complete("s_overflow", 0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    complete("u_max_1", 0);
    issue(1'b0, 32'd1000, 32'd33, 1'b1, 32'd30, 32'd10, 1'b0, 34);
    complete("busy_ignore", 11);
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 34);
    complete("back_to_back", 0);
    issue(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    check("midrst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    check("midrst_no_activity", 32'(seen), 32'd0);
    issue(1'b0, 32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0, 34);
    complete("after_reset", 0);
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd1;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
      eq = s ? 32'($signed(a) / $signed(b)) : a / b;
      er = s ? 32'($signed(a) % $signed(b)) : a % b;
      issue(s, a, b, 1'b1, eq, er, 1'b0, 34);
      complete("random", 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
